// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared types and constants for the UART TX arbiter slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_W          = 8;
    localparam int TIMEOUT_DEFAULT = 200000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module : uart_tx_arbiter_if
// Brief  : Client request/ack bundle plus transmitter enable/data/status.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]        req;
    logic [DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        sent;
    logic                      tx_en;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy;
    logic                      tx_done;

    modport master (
        input  req, req_data, tx_busy, tx_done,
        output ack, sent, tx_en, tx_data
    );

    modport slave (
        output req, req_data, tx_busy, tx_done,
        input  ack, sent, tx_en, tx_data
    );

endinterface : uart_tx_arbiter_if

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
// ============================================================================
// Module : rr_picker
// Brief  : Combinational round-robin select: first set req at/after ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic [IDX_W-1:0]   ptr,
    output logic      [IDX_W-1:0]   idx,
    output logic                    valid
);

    // Scan from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin : p_pick
        int c;
        valid = 1'b0;
        idx   = '0;
        c     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            c = (int'(ptr) + i) % NUM_REQ;
            if (req[c]) begin
                valid = 1'b1;
                idx   = c[IDX_W-1:0];
            end
        end
    end

endmodule : rr_picker

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Round-robin share of one UART transmitter between NUM_REQ clients.
//          Optional frame watchdog: define UART_TX_ARB_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 16,
`ifdef UART_TX_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
`endif
    localparam int IDX_W         = $clog2(NUM_REQ)
) (
    input  wire logic          clk,
    input  wire logic          areset_n,
    uart_tx_arbiter_if.master  bus,
    output logic [IDX_W-1:0]   owner,
`ifdef UART_TX_ARB_TIMEOUT_EN
    output logic               timeout_err,
`endif
    output logic               active
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] ack_q, ack_d, sent_q, sent_d;
    logic               tx_en_q, tx_en_d, active_q, active_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [IDX_W-1:0]   owner_q, owner_d, ptr_q, ptr_d, ptr_next;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic               timeout_err_q, timeout_err_d;
`endif

    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign ptr_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ack_d     = '0;
        sent_d    = '0;
        tx_en_d   = tx_en_q;
        active_d  = active_q;
        tx_data_d = tx_data_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        gap_cnt_d = gap_cnt_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
        frame_cnt_d   = frame_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid && !bus.tx_busy) begin
                    tx_data_d = bus.req_data[{pick_idx, 3'b000} +: DATA_W];
                    owner_d   = pick_idx;
                    ack_d     = NUM_REQ'(1) << pick_idx;
                    tx_en_d   = 1'b1;
                    active_d  = 1'b1;
                    state_d   = ST_SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    frame_cnt_d = '0;
`endif
                end
            end
            ST_SEND: begin
                if (bus.tx_done) begin
                    tx_en_d   = 1'b0;
                    active_d  = 1'b0;
                    sent_d    = NUM_REQ'(1) << owner_q;
                    ptr_d     = ptr_next;
                    state_d   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    gap_cnt_d = GAP_LOAD;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                // Watchdog abort: release the transmitter without a sent pulse.
                else if (frame_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    tx_en_d       = 1'b0;
                    active_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    ptr_d         = ptr_next;
                    state_d       = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    gap_cnt_d     = GAP_LOAD;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= ST_IDLE;
            ack_q     <= '0;
            sent_q    <= '0;
            tx_en_q   <= 1'b0;
            active_q  <= 1'b0;
            tx_data_q <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            gap_cnt_q <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            frame_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            sent_q    <= sent_d;
            tx_en_q   <= tx_en_d;
            active_q  <= active_d;
            tx_data_q <= tx_data_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            gap_cnt_q <= gap_cnt_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
            frame_cnt_q   <= frame_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign bus.ack     = ack_q;
    assign bus.sent    = sent_q;
    assign bus.tx_en   = tx_en_q;
    assign bus.tx_data = tx_data_q;
    assign owner       = owner_q;
    assign active      = active_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule : uart_tx_arbiter

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter (baud generator + TX FSM) between NUM_REQ byte-producing clients. It accepts one byte from the selected client, then holds the transmitter enable and data stable for the whole frame. It releases the transmitter on the frame-done pulse and enforces an optional idle gap between frames. It sits directly above the TX wrapper; its tx_en/tx_data drive that wrapper's enable and data inputs.

Parameters:
NUM_REQ, 4, number of requesting clients (2..8)
GAP_CYCLES, 16, idle clk cycles between frames; 0 = no gap state
TIMEOUT_CYCLES, 200000, watchdog limit per frame (optional feature only)

Ports:
clk  input  1  system clock
areset_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-client send request, level
req_data  input  8*NUM_REQ  client i byte on bits [8i+7:8i]
ack  output  NUM_REQ  one-hot 1-cycle pulse: client byte latched
sent  output  NUM_REQ  one-hot 1-cycle pulse: client frame finished
tx_en  output  1  transmitter enable, held high for the full frame
tx_data  output  8  latched byte, stable while tx_en=1
tx_busy  input  1  transmitter busy flag
tx_done  input  1  transmitter frame-done pulse
owner  output  clog2(NUM_REQ)  index of current/last granted client
active  output  1  high from grant until frame release

Behaviour:
- Reset (areset_n=0, asynchronous): state=IDLE; ack, sent, tx_en, active=0; tx_data=0; owner=0; RR pointer=0; gap counter=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SEND, GAP.
- IDLE: when any req is high and tx_busy=0, pick the first set req at or after the RR pointer, wrapping modulo NUM_REQ.
- On that edge: latch req_data of the winner into tx_data; owner=winner; ack[winner]=1 for 1 cycle; tx_en=1; active=1; go to SEND.
- Latency: req sampled high at edge N gives ack and tx_en high after edge N (visible in cycle N+1).
- IDLE with tx_busy=1: no grant; requests wait.
- A req sampled low is never granted. req may drop after ack with no effect. req held high after ack counts as a new request in the next IDLE.
- SEND: tx_en and tx_data are held constant and new req are ignored.
  - On the edge sampling tx_done=1: tx_en=0; sent[owner]=1 for 1 cycle; RR pointer=(owner+1) mod NUM_REQ.
  - Next state is GAP if GAP_CYCLES>0, else IDLE. active drops on the same edge.
- GAP: counter loads GAP_CYCLES-1 on entry and decrements; at 0, go to IDLE. Requests arriving in GAP are served in the following IDLE.
- Back-to-back frames without gap: sent pulse and the next ack are at least 1 cycle apart (at least one IDLE cycle).
- tx_done while not in SEND: ignored.
- Reset mid-frame: everything returns to reset values immediately; the transmitter shares areset_n and aborts too. No sent pulse is produced.
- Single requester: granted every time; the pointer still advances (harmless).

Optional Feature:
- Macro UART_TX_ARB_TIMEOUT_EN.
- With it defined:
  - A frame counter clears on grant and increments in SEND.
  - On reaching TIMEOUT_CYCLES without tx_done, it forces tx_en=0 and asserts output timeout_err (1 bit, sticky; cleared only by reset).
  - It then advances the RR pointer with no sent pulse and goes to GAP.
- Without it: no counter, no timeout_err port; SEND waits indefinitely for tx_done.

Decomposition:
- Shared package uart_pkg: state enum (IDLE/SEND/GAP), DATA_W=8, and the default timeout constant.
- One natural sub-module: rr_picker (combinational round-robin priority select: req vector + pointer -> winner index + valid).
- The FSM, latches and counters stay in the top level.

Test Plan:
- Only req[2]=1, data 0xA5, tx_done after 10 cycles → ack[2] and tx_en=1 one cycle after req; tx_data=0xA5 throughout; sent[2] pulses one cycle after tx_done; tx_en=0 on the same edge.
- req=4'b1011 held high, pointer 0, GAP_CYCLES=16 → grant order 0,1,3,0; at least 16 idle cycles between each sent and the next ack.
- req[1] raised while tx_busy=1 in IDLE → no ack until tx_busy=0, then ack[1] on the next edge.
- Reset asserted mid-SEND → tx_en, active, ack, sent=0 immediately; owner=0; the next grant after release goes to the lowest requester.
- With UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50, tx_done never arrives → tx_en drops at cycle 50 after grant; timeout_err=1 and stays 1; the next requester is served.
- req toggled high for one cycle during SEND with no req at IDLE → never acked.
